// File: rtl/rx_fifo_if.sv
// rx_fifo_if: receiver-to-consumer byte queue bus; master drives writes/pops, slave is the FIFO.
`default_nettype none

interface rx_fifo_if #(
  parameter int AW = 3
);
  logic [7:0]  din;
  logic        d_rdy;
  logic        rd_en;
  logic        ovr_clr;
  logic [7:0]  dout;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        ovr;

  modport master (
    output din, d_rdy, rd_en, ovr_clr,
    input  dout, empty, full, count, ovr
  );

  modport slave (
    input  din, d_rdy, rd_en, ovr_clr,
    output dout, empty, full, count, ovr
  );
endinterface

`default_nettype wire

// File: rtl/rx_fifo.sv
// rx_fifo: edge-triggered byte capture into a first-word-fall-through queue
// with registered empty/full flags and a sticky overrun flag.
`default_nettype none

module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire       clk,
  input  wire       rst,
  rx_fifo_if.slave  bus
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q;
  logic          ovr_q, ovr_d;
  logic          d_rdy_q;
  logic          wr_stb, wr_ok, rd_ok, ovr_set;

  assign wr_stb = bus.d_rdy & ~d_rdy_q;
  assign rd_ok  = bus.rd_en & ~empty_q;
  // A full queue still takes a write when a pop frees the head slot in the same cycle.
  assign wr_ok   = wr_stb & (~full_q | rd_ok);
  assign ovr_set = wr_stb & full_q & ~rd_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    if (ovr_set)          ovr_d = 1'b1;
    else if (bus.ovr_clr) ovr_d = 1'b0;
  end

  // d_rdy_q resets high so a level already present at release is not a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      d_rdy_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == (AW+1)'(DEPTH));
      ovr_q    <= ovr_d;
      d_rdy_q  <= bus.d_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.din;
  end

  assign bus.dout  = mem[rd_ptr_q];
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
  assign bus.count = count_q;
  assign bus.ovr   = ovr_q;

endmodule

`default_nettype wire

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of byte entries; power of two, >= 2.
REQ-002 SHALL have parameter AW, default 3, pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  input  8  received byte from the receiver; d7..d0, d0 first bit on the line.
REQ-006 SHALL have port d_rdy  input  1  receiver byte-done flag; level, may stay high for multiple clk cycles.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port ovr_clr  input  1  clears the overrun flag.
REQ-009 SHALL have port dout  output  8  head-of-queue byte (first-word-fall-through).
REQ-010 SHALL have port empty  output  1  queue holds zero bytes.
REQ-011 SHALL have port full  output  1  queue holds DEPTH bytes.
REQ-012 SHALL have port count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-013 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-014 SHALL register d_rdy every clk into d_rdy_q and generate wr_stb = d_rdy & ~d_rdy_q; exactly one write per rising edge of d_rdy, regardless of high duration.
REQ-015 SHALL, on wr_stb with full=0, store din at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 SHALL, on rd_en with empty=0, increment rd_ptr modulo DEPTH; the popped byte is the dout value present in that same cycle.
REQ-017 SHALL drive dout combinationally from mem[rd_ptr]; dout is don't-care while empty=1.
REQ-018 SHALL ignore rd_en while empty=1 (no pointer or count change, no error flag).
REQ-019 SHALL, on wr_stb with full=1 and rd_en=0, drop din, leave memory/pointers/count unchanged, and set ovr=1 next cycle.
REQ-020 SHALL, on wr_stb and rd_en in the same cycle with full=1, accept both; count stays DEPTH, no overrun.
REQ-021 SHALL, on wr_stb and rd_en in the same cycle with empty=1, accept the write only; count becomes 1.
REQ-022 SHALL, on wr_stb and rd_en in the same cycle with 0<count<DEPTH, accept both; count unchanged.
REQ-023 SHALL update count: +1 on accepted write only, -1 on accepted read only, unchanged otherwise; never exceeds DEPTH, never underflows.
REQ-024 SHALL register empty = (count==0) and full = (count==DEPTH), both valid in the cycle after the causing edge.
REQ-025 SHALL keep ovr at 1 until a cycle with ovr_clr=1; if a new overrun and ovr_clr coincide, ovr stays 1 (set wins).
REQ-026 SHALL handle pointer wrap: after DEPTH writes and DEPTH reads, pointers return to 0 and data order is preserved (strict FIFO).

Reset
REQ-027 SHALL, while rst=1, asynchronously force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovr=0, d_rdy_q=1.
REQ-028 SHALL NOT clear memory contents on reset.
REQ-029 SHALL NOT generate wr_stb in the first cycle after reset release if d_rdy is already high; a write requires d_rdy to go low first.
REQ-030 SHALL, on reset asserted mid-operation (any count, any pending strobe), discard all stored bytes and lose any in-flight write.

Verification
REQ-031 SHALL verify: reset, pulse d_rdy with din=0x41, 0x42, 0x43 -> count=3, dout=0x41; three rd_en pops return 0x41, 0x42, 0x43; then empty=1, count=0.
REQ-032 SHALL verify: d_rdy held high 5 cycles with din=0x55 -> exactly one entry stored, count=1.
REQ-033 SHALL verify: DEPTH=8, write 0x00..0x07 -> full=1; write 0xAA -> ovr=1, count=8, pops return 0x00..0x07 (0xAA absent); ovr_clr -> ovr=0.
REQ-034 SHALL verify: full, then wr_stb(din=0xEE) with rd_en in same cycle -> count stays 8, no ovr, 0xEE is last byte read.
REQ-035 SHALL verify: 20 writes interleaved with 20 reads, count oscillating 0..3 -> output sequence equals input sequence across pointer wrap.
REQ-036 SHALL verify: rst asserted mid-cycle with count=5 and d_rdy high -> outputs reset immediately; after release with d_rdy still high, no write until d_rdy falls and rises.
